median_window_feeder: RTL and testbench

//  Converts a raster pixel stream into 7-tap horizontal windows for the 7-input compare stage.
//  Its outputs out0..out6 drive compare in0..in6.

---
 rtl/median_window_feeder_if.sv | 29 ++
 rtl/median_window_feeder.sv | 132 +++++++++++++
 tb/tb_median_window_feeder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/median_window_feeder_if.sv
// Handshake bundle between the pixel source, the window feeder and the 7-input sorter.
// The feeder uses the slave view; the pixel source and sorter together use the master view.
interface median_window_feeder_if #(
  parameter int DATA_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic [DATA_W-1:0] out3;
  logic [DATA_W-1:0] out4;
  logic [DATA_W-1:0] out5;
  logic [DATA_W-1:0] out6;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out0, out1, out2, out3, out4, out5, out6, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out0, out1, out2, out3, out4, out5, out6, out_last
  );
endinterface

// File: rtl/median_window_feeder.sv
// Turns a raster pixel stream into 7-tap horizontal windows (one per pixel),
// replicating the border pixel at both ends of every line.
module median_window_feeder #(
  parameter int DATA_W   = 10,
  parameter int LINE_LEN = 640
) (
  input logic                  clk,
  input logic                  rst,
  median_window_feeder_if.slave bus
);

  localparam int PW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [PW-1:0] LAST_PIX = PW'(LINE_LEN - 1);
  localparam logic [PW-1:0] FILL_END = PW'(3);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  typedef logic [6:0][DATA_W-1:0] taps_t;

  state_t        state;
  taps_t         w;
  logic [PW-1:0] pix_cnt;
  logic [1:0]    flush_cnt;
  logic          out_valid;
  logic          out_last;
  logic          slot_free;
  logic          in_ready;
  logic          accept;
  logic          take;

  // Oldest tap drops off w[0]; the new pixel lands in w[6].
  function automatic taps_t shift_in(input taps_t t, input logic [DATA_W-1:0] px);
    return {px, t[6:1]};
  endfunction

  always_comb begin
    slot_free = !out_valid || bus.out_ready;
    case (state)
      IDLE:    in_ready = slot_free;
      FILL:    in_ready = 1'b1;
      RUN:     in_ready = slot_free;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && in_ready;
  assign take   = out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      w         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      pix_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Preloading every tap with p0 gives the left-border replication for free.
          if (accept) begin
            w         <= {7{bus.in_data}};
            pix_cnt   <= PW'(1);
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= FILL;
          end else if (take) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        FILL: begin
          if (accept) begin
            w       <= shift_in(w, bus.in_data);
            pix_cnt <= pix_cnt + PW'(1);
            if (pix_cnt == FILL_END) begin
              out_valid <= 1'b1;
              // A 4-pixel line has already received its last pixel here.
              if (pix_cnt == LAST_PIX) begin
                flush_cnt <= '0;
                state     <= FLUSH;
              end else begin
                state <= RUN;
              end
            end
          end
        end
        RUN: begin
          if (accept) begin
            w         <= shift_in(w, bus.in_data);
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            pix_cnt   <= pix_cnt + PW'(1);
            if (pix_cnt == LAST_PIX) begin
              flush_cnt <= '0;
              state     <= FLUSH;
            end
          end else if (take) begin
            out_valid <= 1'b0;
          end
        end
        FLUSH: begin
          // Right-border replication: re-feed the newest pixel three times.
          if (slot_free) begin
            w         <= shift_in(w, w[6]);
            out_valid <= 1'b1;
            flush_cnt <= flush_cnt + 2'd1;
            if (flush_cnt == 2'd2) begin
              out_last <= 1'b1;
              pix_cnt  <= '0;
              state    <= IDLE;
            end else begin
              out_last <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out0      = w[0];
  assign bus.out1      = w[1];
  assign bus.out2      = w[2];
  assign bus.out3      = w[3];
  assign bus.out4      = w[4];
  assign bus.out5      = w[5];
  assign bus.out6      = w[6];

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed bench for median_window_feeder: LINE_LEN=8 and LINE_LEN=4 instances,
// per-pixel {input, expected window} tables plus reset and stall sequences.
module tb_median_window_feeder;

  typedef logic [6:0][9:0] win_t;
  typedef struct packed {
    logic [9:0] pix;
    win_t       win;
    logic       last;
  } vec_t;

  logic clk;
  logic rst;

  median_window_feeder_if #(.DATA_W(10)) b8 ();
  median_window_feeder_if #(.DATA_W(10)) b4 ();

  median_window_feeder #(.DATA_W(10), .LINE_LEN(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  median_window_feeder #(.DATA_W(10), .LINE_LEN(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vecs [32];
  int   nvec;
  win_t got  [32];
  vec_t vec4 [4];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic win_t mkwin(input int t0, input int t1, input int t2, input int t3,
                                 input int t4, input int t5, input int t6);
    win_t w;
    w[0] = 10'(t0); w[1] = 10'(t1); w[2] = 10'(t2); w[3] = 10'(t3);
    w[4] = 10'(t4); w[5] = 10'(t5); w[6] = 10'(t6);
    return w;
  endfunction

  function automatic win_t win8();
    return {b8.out6, b8.out5, b8.out4, b8.out3, b8.out2, b8.out1, b8.out0};
  endfunction

  function automatic win_t win4();
    return {b4.out6, b4.out5, b4.out4, b4.out3, b4.out2, b4.out1, b4.out0};
  endfunction

  // Reference window: tap k = pixel[clamp(c-3+k, 0, len-1)] for a line of consecutive values.
  task automatic add_line(input int first, input int len);
    for (int c = 0; c < len; c++) begin
      vec_t v;
      v.pix = 10'(first + c);
      for (int k = 0; k < 7; k++) begin
        int j;
        j = c - 3 + k;
        if (j < 0) j = 0;
        if (j > len - 1) j = len - 1;
        v.win[k] = 10'(first + j);
      end
      v.last = (c == len - 1);
      vecs[nvec] = v;
      nvec++;
    end
  endtask

  // vmode 1 toggles in_valid every cycle; stall_at >= 0 holds out_ready low 5 cycles after that many takes.
  task automatic run8(input int vmode, input int stall_at, input string tag);
    int   pi = 0;
    int   wi = 0;
    int   cyc = 0;
    int   stall_left = 0;
    bit   stalled = 0;
    bit   hold_prev = 0;
    bit   prev_ov = 0;
    bit   prev_acc = 0;
    win_t held;
    @(negedge clk);
    while (wi < nvec && cyc < 400) begin
      b8.in_valid = (pi < nvec) && (vmode == 0 || (cyc % 2) == 0);
      b8.in_data  = (pi < nvec) ? vecs[pi].pix : 10'd0;
      if (stall_at >= 0 && wi == stall_at && !stalled) begin
        stall_left = 5;
        stalled    = 1;
      end
      b8.out_ready = (stall_left == 0);
      #1;
      if (hold_prev)
        chk({tag, " hold taps"}, 71'(win8()), 71'(held));
      if (stall_left > 0) begin
        chk({tag, " stall out_valid"}, 71'(b8.out_valid), 71'(1));
        chk({tag, " stall in_ready"}, 71'(b8.in_ready), 71'(0));
        held      = win8();
        hold_prev = 1;
        stall_left--;
      end else begin
        hold_prev = 0;
      end
      if (vmode == 1 && b8.out_valid && !prev_ov)
        chk({tag, " rise after accept"}, 71'(prev_acc), 71'(1));
      if (b8.out_valid && b8.out_ready) begin
        got[wi] = win8();
        chk($sformatf("%s win%0d", tag, wi), {win8(), b8.out_last}, {vecs[wi].win, vecs[wi].last});
        wi++;
      end
      prev_acc = b8.in_valid && b8.in_ready;
      if (prev_acc) pi++;
      prev_ov = b8.out_valid;
      @(negedge clk);
      cyc++;
    end
    b8.in_valid  = 1'b0;
    b8.out_ready = 1'b0;
    if (wi < nvec) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: windows %0d required %0d", tag, wi, nvec);
    end
    chk({tag, " accepted"}, 71'(pi), 71'(nvec));
  endtask

  initial begin
    int acc;
    int cyc;
    int wi;

    vec4[0] = '{pix: 10'd1, win: mkwin(1, 1, 1, 1, 2, 3, 4), last: 1'b0};
    vec4[1] = '{pix: 10'd2, win: mkwin(1, 1, 1, 2, 3, 4, 4), last: 1'b0};
    vec4[2] = '{pix: 10'd3, win: mkwin(1, 1, 2, 3, 4, 4, 4), last: 1'b0};
    vec4[3] = '{pix: 10'd4, win: mkwin(1, 2, 3, 4, 4, 4, 4), last: 1'b1};

    rst = 1'b1;
    b8.in_valid = 1'b0; b8.in_data = '0; b8.out_ready = 1'b0;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 71'(b8.out_valid), 71'(0));
    chk("reset out_last", 71'(b8.out_last), 71'(0));
    chk("reset taps", 71'(win8()), 71'(0));
    chk("reset in_ready", 71'(b8.in_ready), 71'(1));
    rst = 1'b0;

    // Test 1: full throughput single line
    nvec = 0;
    add_line(10, 8);
    run8(0, -1, "t1");
    chk("t1 first window", 71'(got[0]), 71'(mkwin(10, 10, 10, 10, 11, 12, 13)));
    chk("t1 last window", 71'(got[7]), 71'(mkwin(14, 15, 16, 17, 17, 17, 17)));

    // Test 2: downstream stall after the 2nd window
    run8(0, 2, "t2");

    // Test 3: in_valid toggling
    run8(1, -1, "t3");

    // Test 4: two back-to-back lines
    nvec = 0;
    add_line(10, 8);
    add_line(100, 8);
    run8(0, -1, "t4");
    chk("t4 window 9", 71'(got[8]), 71'(mkwin(100, 100, 100, 100, 101, 102, 103)));

    // Test 5: reset mid-line after 5 accepted pixels
    acc = 0;
    cyc = 0;
    @(negedge clk);
    while (acc < 5 && cyc < 30) begin
      b8.in_valid  = 1'b1;
      b8.in_data   = 10'(10 + acc);
      b8.out_ready = 1'b1;
      #1;
      if (b8.in_ready) acc++;
      @(negedge clk);
      cyc++;
    end
    chk("t5 pre-reset accepts", 71'(acc), 71'(5));
    b8.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5 reset out_valid", 71'(b8.out_valid), 71'(0));
    chk("t5 reset out_last", 71'(b8.out_last), 71'(0));
    chk("t5 reset taps", 71'(win8()), 71'(0));
    b8.out_ready = 1'b0;
    nvec = 0;
    add_line(50, 8);
    run8(0, -1, "t5");
    chk("t5 first window", 71'(got[0]), 71'(mkwin(50, 50, 50, 50, 51, 52, 53)));

    // Test 6: LINE_LEN=4 instance
    acc = 0;
    wi  = 0;
    cyc = 0;
    @(negedge clk);
    while (wi < 4 && cyc < 40) begin
      b4.in_valid  = (acc < 4);
      b4.in_data   = (acc < 4) ? vec4[acc].pix : 10'd0;
      b4.out_ready = 1'b1;
      #1;
      if (b4.out_valid) begin
        chk($sformatf("t6 win%0d", wi), {win4(), b4.out_last}, {vec4[wi].win, vec4[wi].last});
        wi++;
      end
      if (b4.in_valid && b4.in_ready) acc++;
      @(negedge clk);
      cyc++;
    end
    b4.in_valid = 1'b0;
    if (wi < 4) begin
      tests++;
      fails++;
      $display("FAIL t6 timeout: windows %0d required 4", wi);
    end
    #1;
    chk("t6 idle after line", 71'(b4.out_valid), 71'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
